// File: rtl/data_mem_pkg.sv
// Shared types and constants for the KGPMini data memory.
package data_mem_pkg;

  localparam int unsigned WORD_W        = 32;
  localparam int unsigned DEFAULT_DEPTH = 1024;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/data_mem_array.sv
// Word array with asynchronous whole-array clear and one synchronous write port.
module data_mem_array
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH     = DEFAULT_DEPTH,
  parameter int unsigned ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [WORD_W-1:0]    wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [WORD_W-1:0]    rdata
);

  word_t mem_q [DEPTH];

  // An X on we falls through to no write, which is the intended behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/data_memory.sv
// MEM-stage word-addressed data memory: combinational read, synchronous write.
// Optional out-of-range error flag enabled by defining DATA_MEM_OOR_ERR_EN.
module data_memory
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH     = DEFAULT_DEPTH,
  parameter int unsigned ADDR_BITS = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a_in,
  output logic [31:0] data_out,
  input  logic [31:0] data,
  input  logic        MemWrite,
  input  logic        MemRead
`ifdef DATA_MEM_OOR_ERR_EN
  ,
  output logic        oor_err
`endif
);

  logic                 in_range;
  logic [ADDR_BITS-1:0] index;
  logic                 wr_en;
  word_t                rd_word;

  // Any set bit above the index field means the word does not exist; no aliasing.
  assign in_range = (a_in[WORD_W-1:ADDR_BITS] == '0);
  assign index    = a_in[ADDR_BITS-1:0];
  assign wr_en    = MemWrite & in_range;

  data_mem_array #(
    .DEPTH     (DEPTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (index),
    .wdata (data),
    .raddr (index),
    .rdata (rd_word)
  );

  always_comb begin
    data_out = '0;
    if (MemRead && in_range) begin
      data_out = rd_word;
    end
  end

`ifdef DATA_MEM_OOR_ERR_EN
  assign oor_err = (MemRead | MemWrite) & ~in_range;
`endif

endmodule

// File: tb/tb_data_memory.sv
// Directed scoreboard bench for data_memory.
module tb_data_memory;
  import data_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] a_in;
  logic [31:0] data_out;
  logic [31:0] data;
  logic        MemWrite;
  logic        MemRead;
`ifdef DATA_MEM_OOR_ERR_EN
  logic        oor_err;
`endif

  data_memory dut (
    .clk      (clk),
    .rst      (rst),
    .a_in     (a_in),
    .data_out (data_out),
    .data     (data),
    .MemWrite (MemWrite),
    .MemRead  (MemRead)
`ifdef DATA_MEM_OOR_ERR_EN
    ,
    .oor_err  (oor_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic expect_out(input string tag, input logic [31:0] val);
    sb.push_back('{tag, val});
  endtask

  task automatic check_out();
    exp_t e;
    #1;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty: data_out=%h required=<none queued>", data_out);
      return;
    end
    e = sb.pop_front();
    assert (data_out === e.val)
    else begin
      n_fail++;
      $error("FAIL %s: data_out=%h required=%h", e.tag, data_out, e.val);
    end
  endtask

`ifdef DATA_MEM_OOR_ERR_EN
  task automatic check_oor(input string tag, input logic exp);
    n_tests++;
    assert (oor_err === exp)
    else begin
      n_fail++;
      $error("FAIL %s: oor_err=%b required=%b", tag, oor_err, exp);
    end
  endtask
`endif

  task automatic do_write(input logic [31:0] addr, input logic [31:0] val);
    @(negedge clk);
    a_in     = addr;
    data     = val;
    MemWrite = 1'b1;
    MemRead  = 1'b0;
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
  endtask

  task automatic read_at(input string tag, input logic [31:0] addr, input logic [31:0] val);
    a_in    = addr;
    MemRead = 1'b1;
    expect_out(tag, val);
    check_out();
  endtask

  initial begin
    a_in     = '0;
    data     = '0;
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    rst      = 1'b1;
    #3;
    rst      = 1'b0;

    // Reset state, no clock edge yet.
    a_in = 32'd1; data = 32'd69; MemRead = 1'b0;
    expect_out("rst_noread", 32'd0);
    check_out();
    read_at("rst_read1", 32'd1, 32'd0);
    read_at("rst_read1023", 32'd1023, 32'd0);

    // Basic write/read.
    do_write(32'd1, 32'd69);
    read_at("wr1_read", 32'd1, 32'd69);
    MemRead = 1'b0;
    expect_out("wr1_noread", 32'd0);
    check_out();

    // Top word.
    do_write(32'd1023, 32'hDEADBEEF);
    read_at("wr1023_read", 32'd1023, 32'hDEADBEEF);
    read_at("wr1_still", 32'd1, 32'd69);

    // Out-of-range write is dropped and reads return 0.
    @(negedge clk);
    a_in = 32'd1024; data = 32'd5; MemWrite = 1'b1; MemRead = 1'b0;
`ifdef DATA_MEM_OOR_ERR_EN
    #1;
    check_oor("oor_wr_flag", 1'b1);
`endif
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    read_at("oor_read0", 32'd0, 32'd0);
`ifdef DATA_MEM_OOR_ERR_EN
    check_oor("inr_rd_flag", 1'b0);
`endif
    read_at("oor_read1024", 32'd1024, 32'd0);
`ifdef DATA_MEM_OOR_ERR_EN
    check_oor("oor_rd_flag", 1'b1);
`endif
    read_at("oor_alias1", 32'h8000_0001, 32'd0);

    // Simultaneous read and write: old word before the edge, new word after.
    @(negedge clk);
    a_in = 32'd5; data = 32'd123; MemWrite = 1'b1; MemRead = 1'b1;
    expect_out("rw_before", 32'd0);
    check_out();
    @(posedge clk);
    expect_out("rw_after", 32'd123);
    check_out();
    MemWrite = 1'b0;

    // X on MemWrite must not write.
    @(negedge clk);
    a_in = 32'd5; data = 32'd999; MemWrite = 1'bx; MemRead = 1'b0;
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    read_at("x_we_nowrite", 32'd5, 32'd123);

    // Asynchronous reset between edges clears immediately.
    @(negedge clk);
    read_at("pre_rst_read1", 32'd1, 32'd69);
    rst = 1'b1;
    expect_out("async_rst_read1", 32'd0);
    check_out();
    read_at("async_rst_read1023", 32'd1023, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    read_at("post_rst_read5", 32'd5, 32'd0);

    // Reset held across a write edge: the write is lost.
    @(negedge clk);
    rst = 1'b1;
    a_in = 32'd2; data = 32'd77; MemWrite = 1'b1; MemRead = 1'b0;
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    rst      = 1'b0;
    read_at("rst_beats_write", 32'd2, 32'd0);

    // Confirm writes resume after reset.
    do_write(32'd2, 32'h0000_A5A5);
    read_at("post_rst_write", 32'd2, 32'h0000_A5A5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
